regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter that shares the register-file write port
//               between an ALU requester (req0) and a load requester (req1).
//               Uses a valid/ready handshake with one registered write stage.
//               Also drives read-hazard flags for the decode-stage rs/rt addresses.
//               Optional macro REGFILE_WB_BYPASS_EN adds forwarding outputs.
//               With the macro defined, an in-flight match raises fwd_x
//               instead of x_hazard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_stall,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_rd,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_rd,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          regwrite,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] writedata,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
`ifdef REGFILE_WB_BYPASS_EN
    output logic          fwd_a,
    output logic          fwd_b,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          rs_hazard,
    output logic          rt_hazard
);

    localparam logic [AW-1:0] c_zero_reg = '0;

    // Index of the requester granted most recently; 1 at reset so req0 wins first.
    logic          r_last_grant;
    logic          r_regwrite;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_writedata;

    logic          w_grant0;
    logic          w_grant1;

    // Round-robin grant: sole requester wins, contention goes to the one not granted last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!wb_stall) begin
            w_grant0 = req0_valid && (!req1_valid || r_last_grant);
            w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Write stage: capture the winning request; rd==0 writes are accepted but never enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite   <= 1'b0;
            r_rd         <= '0;
            r_writedata  <= '0;
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_regwrite   <= (req0_rd != c_zero_reg);
            r_rd         <= req0_rd;
            r_writedata  <= req0_data;
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_regwrite   <= (req1_rd != c_zero_reg);
            r_rd         <= req1_rd;
            r_writedata  <= req1_data;
            r_last_grant <= 1'b1;
        end else begin
            r_regwrite   <= 1'b0;
        end
    end

    assign regwrite  = r_regwrite;
    assign rd        = r_rd;
    assign writedata = r_writedata;

    // A requester that is transferring this cycle no longer counts as pending.
    function automatic logic pending_match(input logic [AW-1:0] addr);
        pending_match = (req0_valid && !w_grant0 && (req0_rd == addr)) ||
                        (req1_valid && !w_grant1 && (req1_rd == addr));
    endfunction

    function automatic logic inflight_match(input logic [AW-1:0] addr);
        inflight_match = r_regwrite && (r_rd == addr);
    endfunction

`ifdef REGFILE_WB_BYPASS_EN
    // In-flight writes are forwarded; only pending requests stall decode.
    always_comb begin
        fwd_a     = (rs != c_zero_reg) && inflight_match(rs);
        fwd_b     = (rt != c_zero_reg) && inflight_match(rt);
        fwd_data  = r_writedata;
        rs_hazard = (rs != c_zero_reg) && pending_match(rs);
        rt_hazard = (rt != c_zero_reg) && pending_match(rt);
    end
`else
    // Both pending and in-flight writes stall decode.
    always_comb begin
        rs_hazard = (rs != c_zero_reg) && (pending_match(rs) || inflight_match(rs));
        rt_hazard = (rt != c_zero_reg) && (pending_match(rt) || inflight_match(rt));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          wb_stall;
    logic          req0_valid;
    logic [AW-1:0] req0_rd;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_rd;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          regwrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] writedata;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rs_hazard;
    logic          rt_hazard;
`ifdef REGFILE_WB_BYPASS_EN
    logic          fwd_a;
    logic          fwd_b;
    logic [DW-1:0] fwd_data;
`endif

    int n_cmp;
    int n_err;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_stall   (wb_stall),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .regwrite   (regwrite),
        .rd         (rd),
        .writedata  (writedata),
        .rs         (rs),
        .rt         (rt),
`ifdef REGFILE_WB_BYPASS_EN
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .fwd_data   (fwd_data),
`endif
        .rs_hazard  (rs_hazard),
        .rt_hazard  (rt_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_stall   = 1'b0;
        req0_valid = 1'b0;
        req0_rd    = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_rd    = '0;
        req1_data  = '0;
        rs         = '0;
        rt         = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("reset_regwrite", {63'd0, regwrite}, 64'd0);
        chk("reset_rd", {59'd0, rd}, 64'd0);
        chk("reset_writedata", {32'd0, writedata}, 64'd0);
        do_reset();

        // Single ALU write
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("t1_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t1_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("t1_regwrite", {63'd0, regwrite}, 64'd1);
        chk("t1_rd", {59'd0, rd}, 64'd5);
        chk("t1_wdata", {32'd0, writedata}, 64'hDEADBEEF);
        tick();
        chk("t1_idle_regwrite", {63'd0, regwrite}, 64'd0);
        chk("t1_idle_rd_hold", {59'd0, rd}, 64'd5);

        // Contention: alternate req0, req1, req0, req1
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ready0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("t2_ready1", {63'd0, req1_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            chk("t2_regwrite", {63'd0, regwrite}, 64'd1);
            chk("t2_rd", {59'd0, rd}, (i % 2 == 0) ? 64'd3 : 64'd4);
            chk("t2_wdata", {32'd0, writedata}, (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Write to register 0 is accepted but dropped
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFF;
        #1;
        chk("t3_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("t3_regwrite", {63'd0, regwrite}, 64'd0);

        // Stall with pending request: hazard, then transfer, then in-flight
        wb_stall = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hCAFE0007;
        rs = 5'd7; rt = 5'd0;
        #1;
        chk("t4_stall_ready0", {63'd0, req0_ready}, 64'd0);
        chk("t4_stall_rs_haz", {63'd0, rs_hazard}, 64'd1);
        chk("t4_stall_rt_haz", {63'd0, rt_hazard}, 64'd0);
        tick();
        chk("t4_stall_regwrite", {63'd0, regwrite}, 64'd0);
        wb_stall = 1'b0;
        #1;
        chk("t4_go_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t4_go_rs_haz", {63'd0, rs_hazard}, 64'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("t4_regwrite", {63'd0, regwrite}, 64'd1);
        chk("t4_rd", {59'd0, rd}, 64'd7);
`ifdef REGFILE_WB_BYPASS_EN
        chk("t4_inflight_rs_haz", {63'd0, rs_hazard}, 64'd0);
        chk("t4_fwd_a", {63'd0, fwd_a}, 64'd1);
        chk("t4_fwd_b", {63'd0, fwd_b}, 64'd0);
        chk("t4_fwd_data", {32'd0, fwd_data}, 64'hCAFE0007);
`else
        chk("t4_inflight_rs_haz", {63'd0, rs_hazard}, 64'd1);
`endif
        chk("t4_inflight_rt_haz", {63'd0, rt_hazard}, 64'd0);
        tick();
        chk("t4_after_rs_haz", {63'd0, rs_hazard}, 64'd0);

        // Pending load on rt while stalled
        wb_stall = 1'b1;
        req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'h0C;
        rs = 5'd3; rt = 5'd12;
        #1;
        chk("t6_ready1", {63'd0, req1_ready}, 64'd0);
        chk("t6_rt_haz", {63'd0, rt_hazard}, 64'd1);
        chk("t6_rs_haz", {63'd0, rs_hazard}, 64'd0);
        tick();
        idle_inputs();

        // Mid-operation reset after a req0 transfer
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
        tick();
        req0_valid = 1'b0;
        chk("t5_regwrite_pre", {63'd0, regwrite}, 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_regwrite_async", {63'd0, regwrite}, 64'd0);
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hA1;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'hB2;
        #1;
        chk("t5_ready0", {63'd0, req0_ready}, 64'd1);
        chk("t5_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        idle_inputs();
        chk("t5_rd", {59'd0, rd}, 64'd1);
        chk("t5_wdata", {32'd0, writedata}, 64'hA1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
